id_hazard_scoreboard: RTL and testbench

Tracks in-flight register writes between the decode stage and write-back. From the current decode operands it generates the `hazard` stall that gates the decode-stage control signals to a bubble. With forwarding compiled in, it also produces registered forwarding selects for the execute stage. It sits beside the decode stage, fed by decode-stage operand/control fields and by pipeline freeze/flush.

---
 rtl/id_hazard_scoreboard_pkg.sv | 36 +++
 rtl/id_hazard_scoreboard_if.sv | 34 +++
 rtl/id_hazard_scoreboard_sb_match.sv | 13 +
 rtl/id_hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Slot struct width follows REG_W_DEF; forwarding build selected by ID_HAZARD_FORWARDING_EN.
package id_hazard_scoreboard_pkg;

    localparam int REG_W_DEF = 32'd4;
    localparam int CNT_W_DEF = 32'd16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] dest;
        logic                 is_load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '{valid: 1'b0, dest: {REG_W_DEF{1'b0}}, is_load: 1'b0};

    // Newest producer wins; a bubble entering execute never forwards.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit,
                                            input logic bubble);
        logic [1:0] sel;
        if (bubble) begin
            sel = FWD_RF;
        end else if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: operand/control fields in,
// stall, forwarding selects and stall counter out.
interface id_hazard_scoreboard_if
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             freeze;
    logic             flush;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_rn_valid;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             hazard;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output freeze, flush, id_src1, id_src2, id_rn_valid, id_two_src,
               id_dest, id_wb_en, id_mem_r_en,
        input  hazard, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  freeze, flush, id_src1, id_src2, id_rn_valid, id_two_src,
               id_dest, id_wb_en, id_mem_r_en,
        output hazard, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/id_hazard_scoreboard_sb_match.sv
// Combinational comparator of one scoreboard slot against one decode source.
module sb_match
    import id_hazard_scoreboard_pkg::*;
(
    input  sb_slot_t             slot,
    input  logic                 src_valid,
    input  logic [REG_W_DEF-1:0] src,
    output logic                 match,
    output logic                 load_match
);
    assign match      = slot.valid & src_valid & (slot.dest == src);
    assign load_match = match & slot.is_load;
endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard tracking execute/memory writers.
// Define ID_HAZARD_FORWARDING_EN for load-use-only stalls plus registered forwarding selects.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    id_hazard_scoreboard_if.slave bus
);
    sb_slot_t         ex_r;
    sb_slot_t         mem_r;
    sb_slot_t         ex_next_s;
    logic [REG_W-1:0] dest_s;
    logic             ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s;
    logic             ex_l1_s, ex_l2_s, mem_l1_s, mem_l2_s;
    logic             hazard_s;
    logic [CNT_W-1:0] cnt_r;

    assign dest_s = bus.id_dest;

    sb_match u_ex_src1 (.slot(ex_r), .src_valid(bus.id_rn_valid), .src(bus.id_src1),
                        .match(ex_m1_s), .load_match(ex_l1_s));
    sb_match u_ex_src2 (.slot(ex_r), .src_valid(bus.id_two_src), .src(bus.id_src2),
                        .match(ex_m2_s), .load_match(ex_l2_s));
    sb_match u_mem_src1 (.slot(mem_r), .src_valid(bus.id_rn_valid), .src(bus.id_src1),
                         .match(mem_m1_s), .load_match(mem_l1_s));
    sb_match u_mem_src2 (.slot(mem_r), .src_valid(bus.id_two_src), .src(bus.id_src2),
                         .match(mem_m2_s), .load_match(mem_l2_s));

    // Incoming execute slot; a stall or a squash turns it into a bubble.
    always_comb begin
        ex_next_s         = SLOT_EMPTY;
        ex_next_s.valid   = bus.id_wb_en & ~hazard_s & ~bus.flush;
        ex_next_s.dest    = dest_s;
        ex_next_s.is_load = bus.id_mem_r_en;
    end

`ifdef ID_HAZARD_FORWARDING_EN
    logic       unused_load_s;
    logic       bubble_s;
    logic [1:0] sel1_r;
    logic [1:0] sel2_r;

    assign unused_load_s = mem_l1_s ^ mem_l2_s;
    assign bubble_s      = hazard_s | bus.flush;

    // Only a load still in execute has no result ready to forward.
    always_comb begin
        hazard_s = ex_l1_s | ex_l2_s;
    end

    // Forwarding selects travel with the consumer into execute.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel1_r <= FWD_RF;
            sel2_r <= FWD_RF;
        end else if (!bus.freeze) begin
            sel1_r <= fwd_pick(ex_m1_s, mem_m1_s, bubble_s);
            sel2_r <= fwd_pick(ex_m2_s, mem_m2_s, bubble_s);
        end
    end

    assign bus.fwd_sel1 = sel1_r;
    assign bus.fwd_sel2 = sel2_r;
`else
    logic unused_load_s;

    assign unused_load_s = ^{ex_l1_s, ex_l2_s, mem_l1_s, mem_l2_s};

    // Without forwarding every in-flight writer of a source blocks decode.
    always_comb begin
        hazard_s = ex_m1_s | ex_m2_s | mem_m1_s | mem_m2_s;
    end

    assign bus.fwd_sel1 = FWD_RF;
    assign bus.fwd_sel2 = FWD_RF;
`endif

    // Slot pipeline: execute slot moves to memory unless the pipe is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r  <= SLOT_EMPTY;
            mem_r <= SLOT_EMPTY;
        end else if (!bus.freeze) begin
            mem_r <= ex_r;
            ex_r  <= ex_next_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.freeze && hazard_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.hazard    = hazard_s;
    assign bus.stall_cnt = cnt_r;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard (both ID_HAZARD_FORWARDING_EN builds).
module tb_id_hazard_scoreboard;
`ifdef ID_HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   st;

    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) bus ();
    id_hazard_scoreboard_if #(.REG_W(4), .CNT_W(4))  sat_bus ();

    assign sat_bus.freeze      = bus.freeze;
    assign sat_bus.flush       = bus.flush;
    assign sat_bus.id_src1     = bus.id_src1;
    assign sat_bus.id_src2     = bus.id_src2;
    assign sat_bus.id_rn_valid = bus.id_rn_valid;
    assign sat_bus.id_two_src  = bus.id_two_src;
    assign sat_bus.id_dest     = bus.id_dest;
    assign sat_bus.id_wb_en    = bus.id_wb_en;
    assign sat_bus.id_mem_r_en = bus.id_mem_r_en;

    id_hazard_scoreboard #(.REG_W(4), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    id_hazard_scoreboard #(.REG_W(4), .CNT_W(4))  u_dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

    // Model: history of what entered execute, newest first.
    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic       ld;
    } ent_t;

    ent_t hist[$];
    int   exp_cnt = 0;
    int   exp_cnt_sat = 0;
    int   exp_sel1 = 0;
    int   exp_sel2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Age of the youngest in-flight writer of a source (0 = execute, 1 = memory), -1 if none.
    function automatic int writer_age(input logic sv, input logic [3:0] s);
        if (sv) begin
            for (int a = 0; a < hist.size() && a < 2; a++) begin
                if (hist[a].v && hist[a].d == s) return a;
            end
        end
        return -1;
    endfunction

    function automatic int model_hazard();
        int a1 = writer_age(bus.id_rn_valid, bus.id_src1);
        int a2 = writer_age(bus.id_two_src, bus.id_src2);
        if (FWD) return ((a1 == 0 || a2 == 0) && hist[0].ld) ? 1 : 0;
        return (a1 >= 0 || a2 >= 0) ? 1 : 0;
    endfunction

    function automatic int sel_of(input int age);
        if (!FWD) return 0;
        return (age == 0) ? 1 : ((age == 1) ? 2 : 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                hist.delete();
                exp_cnt = 0;
                exp_cnt_sat = 0;
                exp_sel1 = 0;
                exp_sel2 = 0;
            end else if (!bus.freeze) begin
                int   hz;
                bit   bub;
                ent_t e;
                hz  = model_hazard();
                bub = (hz != 0) || bus.flush;
                exp_sel1 = bub ? 0 : sel_of(writer_age(bus.id_rn_valid, bus.id_src1));
                exp_sel2 = bub ? 0 : sel_of(writer_age(bus.id_two_src, bus.id_src2));
                if (hz != 0) begin
                    exp_cnt     = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
                    exp_cnt_sat = (exp_cnt_sat < 15) ? exp_cnt_sat + 1 : 15;
                end
                e.v  = bus.id_wb_en && !bub;
                e.d  = bus.id_dest;
                e.ld = bus.id_mem_r_en;
                hist.push_front(e);
                if (hist.size() > 2) void'(hist.pop_back());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("hazard", bus.hazard, model_hazard());
            chk("fwd_sel1", bus.fwd_sel1, exp_sel1);
            chk("fwd_sel2", bus.fwd_sel2, exp_sel2);
            chk("stall_cnt", bus.stall_cnt, exp_cnt);
            chk("sat_hazard", sat_bus.hazard, model_hazard());
            chk("sat_sel1", sat_bus.fwd_sel1, exp_sel1);
            chk("sat_sel2", sat_bus.fwd_sel2, exp_sel2);
            chk("sat_cnt", sat_bus.stall_cnt, exp_cnt_sat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s1, input int rv, input int s2, input int ts,
                         input int d, input int wb, input int ld);
        bus.id_src1     = 4'(s1);
        bus.id_rn_valid = (rv != 0);
        bus.id_src2     = 4'(s2);
        bus.id_two_src  = (ts != 0);
        bus.id_dest     = 4'(d);
        bus.id_wb_en    = (wb != 0);
        bus.id_mem_r_en = (ld != 0);
    endtask

    task automatic drive_idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold the decode instruction until it issues; returns stall cycles seen.
    task automatic run_until_issue(output int stalls);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (!bus.hazard) begin
                step();
                return;
            end
            stalls++;
            step();
        end
        chk("issue_timeout", stalls, -1);
    endtask

    typedef struct {
        int s1, rv, s2, ts, d, wb, ld, fl, fz;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{5, 1, 0, 0, 5, 1, 1, 0, 0};
        tbl[1] = '{5, 1, 6, 1, 6, 1, 0, 0, 0};
        tbl[2] = '{6, 1, 5, 1, 7, 1, 0, 0, 1};
        tbl[3] = '{6, 1, 5, 1, 7, 1, 0, 1, 0};
        tbl[4] = '{7, 1, 7, 1, 7, 1, 1, 0, 0};
        tbl[5] = '{7, 1, 2, 1, 3, 0, 0, 0, 0};
        tbl[6] = '{3, 1, 7, 1, 4, 1, 0, 0, 0};
        tbl[7] = '{4, 1, 4, 0, 4, 1, 1, 1, 1};
        tbl[8] = '{4, 1, 4, 1, 8, 1, 0, 0, 0};
        tbl[9] = '{8, 1, 4, 1, 9, 1, 0, 0, 0};

        rst = 1'b0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive_idle();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hazard", bus.hazard, 0);
            chk("rst_sel1", bus.fwd_sel1, 0);
            chk("rst_cnt", bus.stall_cnt, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        step();

        // ADD R1 then SUB R2,R1,R3
        drive(2, 1, 3, 1, 1, 1, 0);
        step();
        drive(1, 1, 3, 1, 2, 1, 0);
        run_until_issue(st);
        chk("A_stalls", st, FWD ? 0 : 2);
        @(negedge clk);
        #1;
        chk("A_sel1", bus.fwd_sel1, FWD ? 1 : 0);
        chk("A_sel2", bus.fwd_sel2, 0);
        drive_idle();
        step();
        step();
        chk("A_cnt", bus.stall_cnt, FWD ? 0 : 2);

        // LDR R4 then ADD R5,R4,R4
        drive(0, 1, 0, 0, 4, 1, 1);
        step();
        drive(4, 1, 4, 1, 5, 1, 0);
        run_until_issue(st);
        chk("B_stalls", st, FWD ? 1 : 2);
        @(negedge clk);
        #1;
        chk("B_sel1", bus.fwd_sel1, FWD ? 2 : 0);
        chk("B_sel2", bus.fwd_sel2, FWD ? 2 : 0);
        drive_idle();
        step();
        step();
        chk("B_cnt", bus.stall_cnt, FWD ? 1 : 4);

        // MOV R1 twice, then ADD R2,R1,R0
        drive(0, 0, 0, 0, 1, 1, 0);
        step();
        step();
        drive(1, 1, 0, 1, 2, 1, 0);
        run_until_issue(st);
        chk("C_stalls", st, FWD ? 0 : 2);
        @(negedge clk);
        #1;
        chk("C_sel1", bus.fwd_sel1, FWD ? 1 : 0);
        chk("C_sel2", bus.fwd_sel2, 0);

        // Reset with both slots valid
        drive(0, 0, 0, 0, 6, 1, 0);
        step();
        drive(0, 0, 0, 0, 7, 1, 0);
        step();
        drive(6, 1, 7, 1, 8, 1, 0);
        #1;
        chk("D_pre_hazard", bus.hazard, FWD ? 0 : 1);
        rst = 1'b0;
        #1;
        chk("D_hazard", bus.hazard, 0);
        chk("D_sel1", bus.fwd_sel1, 0);
        chk("D_sel2", bus.fwd_sel2, 0);
        chk("D_cnt", bus.stall_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        // Flush of a dependent load, then freeze
        drive(0, 0, 0, 0, 3, 1, 0);
        step();
        drive(3, 1, 3, 1, 9, 1, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(9, 1, 9, 1, 10, 1, 0);
        @(negedge clk);
        #1;
        chk("E_hazard", bus.hazard, 0);
        chk("E_sel1", bus.fwd_sel1, 0);
        chk("E_sel2", bus.fwd_sel2, 0);
        step();
        drive(10, 1, 0, 0, 11, 1, 0);
        bus.freeze = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("F_hazard", bus.hazard, FWD ? 0 : 1);
            chk("F_cnt", bus.stall_cnt, FWD ? 0 : 1);
            step();
        end
        bus.freeze = 1'b0;
        run_until_issue(st);
        chk("F_stalls", st, FWD ? 0 : 2);
        @(negedge clk);
        #1;
        chk("F_sel1", bus.fwd_sel1, FWD ? 1 : 0);
        chk("F_cnt_after", bus.stall_cnt, FWD ? 0 : 3);

        // Mixed vectors
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].s1, tbl[i].rv, tbl[i].s2, tbl[i].ts, tbl[i].d, tbl[i].wb, tbl[i].ld);
            bus.flush  = (tbl[i].fl != 0);
            bus.freeze = (tbl[i].fz != 0);
            step();
        end
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;

        // Sustained load-use to drive the narrow counter into saturation
        drive(1, 1, 0, 0, 1, 1, 1);
        repeat (40) step();
        drive_idle();
        repeat (3) step();
        chk("sat_final", sat_bus.stall_cnt, 15);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
